// File: rtl/pixart_i2c_target.sv
// I2C target emulating the Pixart IR camera: accepts register writes, serves blob reports.
// Ports: clk, reset (async high), i2c_scl, i2c_sda_in, i2c_sda_out/dir, blob_*, wr_*, busy.
module pixart_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h58,
    parameter int         NBYTES      = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_out,
    output logic       i2c_sda_dir,
    input  logic [9:0] blob_x,
    input  logic [9:0] blob_y,
    input  logic [3:0] blob_size,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
    logic scl_s, sda_s, scl_p, sda_p;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_c, stop_c;

    state_t state_q, state_n;
    logic [3:0] cnt_q, cnt_n;
    logic [7:0] sh_q, sh_n;
    logic rw_q, rw_n, first_q, first_n;
    logic dir_q, dir_n, busy_q, busy_n;
    logic [7:0] ptr_q, ptr_n;
    logic [IW-1:0] idx_q, idx_n;
    logic [9:0] bx_q, bx_n, by_q, by_n;
    logic [3:0] bs_q, bs_n;
    logic wv_q, wv_n;
    logic [7:0] wa_q, wa_n, wd_q, wd_n;
    logic [7:0] cur_byte;

    // Idle bus is high on both lines, so synchronizers reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_p  <= 1'b1;
            sda_p  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], i2c_scl};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], i2c_sda_in};
            scl_p  <= scl_s;
            sda_p  <= sda_s;
        end
    end

    assign scl_s    = scl_sr[SYNC_STAGES-1];
    assign sda_s    = sda_sr[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign sda_rise = sda_s & ~sda_p;
    assign sda_fall = ~sda_s & sda_p;
    assign start_c  = sda_fall & scl_s & scl_p;
    assign stop_c   = sda_rise & scl_s & scl_p;

    // Report byte at the current read index, from the snapshot taken at read start.
    always_comb begin
        cur_byte = 8'hFF;
        case (int'(idx_q))
            0: cur_byte = 8'h00;
            1: cur_byte = bx_q[7:0];
            2: cur_byte = by_q[7:0];
            3: cur_byte = {by_q[9:8], bx_q[9:8], bs_q};
            default: cur_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        sh_n    = sh_q;
        rw_n    = rw_q;
        first_n = first_q;
        dir_n   = dir_q;
        busy_n  = busy_q;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        bx_n    = bx_q;
        by_n    = by_q;
        bs_n    = bs_q;
        wv_n    = 1'b0;
        wa_n    = wa_q;
        wd_n    = wd_q;
        if (start_c) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            dir_n   = 1'b0;
        end else if (stop_c) begin
            state_n = IDLE;
            dir_n   = 1'b0;
            busy_n  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        sh_n  = {sh_q[6:0], sda_s};
                        cnt_n = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (sh_q[7:1] == DEV_ADDR) begin
                            dir_n   = 1'b1;
                            busy_n  = 1'b1;
                            rw_n    = sh_q[0];
                            state_n = ADDR_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n = 4'd0;
                        if (!rw_q) begin
                            dir_n   = 1'b0;
                            first_n = 1'b1;
                            state_n = WR_BYTE;
                        end else begin
                            // Byte 0 is constant zero, so its MSB drives low now.
                            bx_n    = blob_x;
                            by_n    = blob_y;
                            bs_n    = blob_size;
                            idx_n   = '0;
                            dir_n   = 1'b1;
                            sh_n    = 8'h00;
                            cnt_n   = 4'd1;
                            state_n = RD_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        sh_n  = {sh_q[6:0], sda_s};
                        cnt_n = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        dir_n   = 1'b1;
                        state_n = WR_ACK;
                        if (first_q) begin
                            ptr_n = sh_q;
                        end else begin
                            wv_n  = 1'b1;
                            wa_n  = ptr_q;
                            wd_n  = sh_q;
                            ptr_n = ptr_q + 8'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        dir_n   = 1'b0;
                        first_n = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            dir_n   = 1'b0;
                            state_n = RD_ACK;
                        end else begin
                            dir_n = ~sh_q[7];
                            sh_n  = {sh_q[6:0], 1'b0};
                            cnt_n = cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            busy_n  = 1'b0;
                            state_n = WAIT_STOP;
                        end else if (idx_q == IW'(NBYTES - 1)) begin
                            idx_n = '0;
                        end else begin
                            idx_n = idx_q + 1'b1;
                        end
                    end else if (scl_fall) begin
                        dir_n   = ~cur_byte[7];
                        sh_n    = {cur_byte[6:0], 1'b0};
                        cnt_n   = 4'd1;
                        state_n = RD_BYTE;
                    end
                end
                WAIT_STOP: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'd0;
            rw_q    <= 1'b0;
            first_q <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= 8'd0;
            idx_q   <= '0;
            bx_q    <= 10'd0;
            by_q    <= 10'd0;
            bs_q    <= 4'd0;
            wv_q    <= 1'b0;
            wa_q    <= 8'd0;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            sh_q    <= sh_n;
            rw_q    <= rw_n;
            first_q <= first_n;
            dir_q   <= dir_n;
            busy_q  <= busy_n;
            ptr_q   <= ptr_n;
            idx_q   <= idx_n;
            bx_q    <= bx_n;
            by_q    <= by_n;
            bs_q    <= bs_n;
            wv_q    <= wv_n;
            wa_q    <= wa_n;
            wd_q    <= wd_n;
        end
    end

    assign i2c_sda_out = 1'b0;
    assign i2c_sda_dir = dir_q;
    assign wr_valid    = wv_q;
    assign wr_addr     = wa_q;
    assign wr_data     = wd_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_pixart_i2c_target.sv
// Testbench for pixart_i2c_target: bit-banged I2C initiator plus transaction-level model.
// Ports: drives all DUT inputs, checks writes, read frames, ACKs, busy and SDA release.
module tb_pixart_i2c_target;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [9:0] bx = 10'h2A5;
    logic [9:0] by = 10'h1F3;
    logic [3:0] bs = 4'h3;
    logic       sda_out, dir, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;
    wire        sda_bus = m_sda & ~dir;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] log_q[$];
    logic [7:0]  tx[$];
    logic [7:0]  rb[$];
    logic [7:0]  mptr = 8'h00;
    bit          quiet = 1'b0;

    always #5 clk = ~clk;

    pixart_i2c_target dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (scl),
        .i2c_sda_in (sda_bus),
        .i2c_sda_out(sda_out),
        .i2c_sda_dir(dir),
        .blob_x     (bx),
        .blob_y     (by),
        .blob_size  (bs),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_valid) begin
            log_q.push_back({wr_addr, wr_data});
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual=%h required=none",
                         {wr_addr, wr_data});
            end else begin
                chk("wr_pair", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
        if (quiet) chk("sda_quiet", dir, 0);
    end

    task automatic wq;
        repeat (Q) @(negedge clk);
    endtask

    task automatic wbit(input bit b);
        m_sda = b; wq; scl = 1'b1; wq; wq; scl = 1'b0; wq;
    endtask

    task automatic rbit(output bit b);
        m_sda = 1'b1; wq; scl = 1'b1; wq; b = sda_bus; wq; scl = 1'b0; wq;
    endtask

    task automatic wbyte(input logic [7:0] v, output bit ack);
        bit a;
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(a);
        ack = ~a;
    endtask

    task automatic rbyte(output logic [7:0] v, input bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
        wbit(!ack);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wq; scl = 1'b1; wq; m_sda = 1'b0; wq; scl = 1'b0; wq;
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wq; scl = 1'b1; wq; m_sda = 1'b1; wq; wq;
    endtask

    // Write transaction model: first data byte loads the pointer, the rest are reported.
    task automatic wr_txn(input logic [6:0] a);
        bit ack;
        bit match;
        match = (a == 7'h58);
        i2c_start;
        wbyte({a, 1'b0}, ack);
        chk("addr_ack", ack, match);
        chk("busy_addr", busy, match);
        for (int i = 0; i < tx.size(); i++) begin
            if (match) begin
                if (i == 0) mptr = tx[i];
                else begin
                    exp_q.push_back({mptr, tx[i]});
                    mptr = mptr + 8'd1;
                end
            end
            wbyte(tx[i], ack);
            chk("data_ack", ack, match);
        end
        i2c_stop;
        chk("busy_stop", busy, 0);
        chk("wr_drain", exp_q.size(), 0);
    endtask

    // Read transaction model: 16-byte frame captured at read start.
    task automatic rd_txn(input int n, input int chg);
        logic [7:0] fr[16];
        logic [7:0] v;
        bit ack;
        fr[0] = 8'h00;
        fr[1] = bx[7:0];
        fr[2] = by[7:0];
        fr[3] = {by[9:8], bx[9:8], bs};
        for (int i = 4; i < 16; i++) fr[i] = 8'hFF;
        rb = {};
        i2c_start;
        wbyte(8'hB1, ack);
        chk("rd_addr_ack", ack, 1);
        chk("rd_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i == chg) begin
                bx = 10'h3C7;
                by = 10'h055;
                bs = 4'hF;
            end
            rbyte(v, i != n - 1);
            chk("rd_byte", v, fr[i % 16]);
            rb.push_back(v);
        end
        wq;
        chk("rd_busy_nack", busy, 0);
        chk("rd_release", dir, 0);
        i2c_stop;
    endtask

    initial begin
        bit ack;
        repeat (5) @(negedge clk);
        chk("rst_dir", dir, 0);
        chk("rst_out", sda_out, 0);
        chk("rst_valid", wr_valid, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        wq;

        tx = '{8'h30, 8'h01};
        wr_txn(7'h58);
        chk("t1_count", log_q.size(), 1);
        chk("t1_pair", log_q[0], 16'h3001);

        tx = '{8'h06, 8'h90, 8'hC0};
        wr_txn(7'h58);
        tx = '{8'hFF, 8'hAA, 8'hBB};
        wr_txn(7'h58);
        chk("t2_count", log_q.size(), 5);
        chk("t2_p1", log_q[1], 16'h0690);
        chk("t2_p2", log_q[2], 16'h07C0);
        chk("t2_p3", log_q[3], 16'hFFAA);
        chk("t2_p4", log_q[4], 16'h00BB);

        rd_txn(4, -1);
        chk("t3_b0", rb[0], 8'h00);
        chk("t3_b1", rb[1], 8'hA5);
        chk("t3_b2", rb[2], 8'hF3);
        chk("t3_b3", rb[3], 8'h63);

        quiet = 1'b1;
        tx = '{8'h10, 8'h55};
        wr_txn(7'h21);
        quiet = 1'b0;
        chk("t4_count", log_q.size(), 5);
        tx = '{8'h40, 8'h12};
        wr_txn(7'h58);
        chk("t4_pair", log_q[5], 16'h4012);

        rd_txn(20, 2);
        chk("t5_b4", rb[4], 8'hFF);
        chk("t5_b15", rb[15], 8'hFF);
        chk("t5_b16", rb[16], 8'h00);
        chk("t5_b17", rb[17], 8'hA5);
        chk("t5_b19", rb[19], 8'h63);

        i2c_start;
        wbyte(8'hB1, ack);
        chk("t6_ack", ack, 1);
        m_sda = 1'b1; wq; scl = 1'b1; wq;
        chk("t6_drive", dir, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_release", dir, 0);
        chk("t6_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wq;
        scl = 1'b0;
        wq;
        rd_txn(2, -1);
        chk("t6_b1", rb[1], 8'hC7);

        chk("sda_out_low", sda_out, 0);
        chk("final_log", log_q.size(), 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
